dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase-increment input. On a start pulse it captures sweep settings, then emits a staircase of `step` values from `start_step` toward `stop_step` in `delta` increments. Each value is held for a programmed dwell time, and a sync pulse marks every sweep start for scope/stat triggering. It sits between the register file and the DDS `step` input in the DDS block, replacing the static step register when a sweep is enabled.

## Interface
- `STEP_WIDTH`, 32, width of step/delta/limits (DDS phase increment).
- `DWELL_WIDTH`, 24, width of dwell counter.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; capture settings, begin sweep.
- `stop`  in  1  pulse; abort sweep.
- `hold`  in  1  level; freeze dwell counter while high.
- `repeat_en`  in  1  1 = restart sweep at end, 0 = single shot.
- `start_step`  in  STEP_WIDTH  first step value (unsigned).
- `stop_step`  in  STEP_WIDTH  upper limit, inclusive.
- `delta`  in  STEP_WIDTH  increment per step (unsigned).
- `dwell`  in  DWELL_WIDTH  hold time; each value lasts `dwell`+1 cycles.
- `bounce_en`  in  1  present only with `DDS_SWEEP_BOUNCE_EN`.
- `step_out`  out  STEP_WIDTH  to DDS `step`.
- `step_valid`  out  1  one-cycle pulse when `step_out` is loaded.
- `sync_out`  out  1  one-cycle pulse on each sweep (re)start.
- `busy`  out  1  high in any non-IDLE state.
- `done`  out  1  one-cycle pulse on natural completion, not on `stop`.

## Operation
- States: IDLE, UP, plus DOWN under the macro.
- Shadow registers capture `start_step`, `stop_step`, `delta`, `dwell`, `repeat_en` and `bounce_en` on the accepted start. Input changes mid-sweep have no effect.
- IDLE, `start`=1: `step_out`←`start_step`, `cnt`←`dwell`, `step_valid`=`sync_out`=1, go to UP.
- UP, `cnt`≠0 and `hold`=0: decrement `cnt`. With `hold`=1, nothing changes.
- UP, `cnt`=0 and `hold`=0: compute `next` = `step_out`+`delta` in STEP_WIDTH+1 bits.
  - If there is no carry, `next` ≤ `stop_step` and `delta`≠0: `step_out`←`next`, `cnt`←`dwell`, `step_valid`=1.
  - Otherwise the end of the ramp is reached. With `repeat_en`: reload `start_step`, `step_valid`=`sync_out`=1. Without it: `done`=1, go to IDLE, `step_out` holds its last value.
- `delta`=0 is a single-step sweep that ends at the first advance.
- `start_step` > `stop_step`: `start_step` is emitted for one dwell, then the sweep ends.
- `stop` has priority over all events including a simultaneous `start`. It goes to IDLE on the next edge with no `done`; `step_out` holds.
- `start` while busy restarts the sweep exactly as from IDLE (recapture, sync pulse).
- `reset`: IDLE, `step_out`=0, `cnt`=0, all pulses 0, `busy`=0, shadows cleared. Reset mid-sweep aborts immediately.

## Timing
- `step_out` updates on the edge after `start` is sampled, so latency is 1 cycle.
- Each step value is stable for exactly `dwell`+1 cycles, plus any cycles with `hold`=1.
- `step_valid`, `sync_out` and `done` are registered and coincide with the `step_out` update cycle.
- `busy` rises on the same edge as the first `step_valid` and falls on the same edge as the `done` pulse.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `DDS_SWEEP_BOUNCE_EN` defined: adds the `bounce_en` port and the DOWN state.
  - With `bounce_en`=1, reaching the UP end condition goes to DOWN instead of ending. `step_out` is loaded with `step_out`−`delta` if there is no borrow and the result is ≥ `start_step`; otherwise the bottom-end rule applies at once.
  - In DOWN, when the next value would borrow or fall below `start_step`: with `repeat_en`, go to UP, `step_out`←`start_step`, `sync_out`=1. Without it, `done`=1 and go to IDLE.
- Undefined: no port, no DOWN state; up-ramp only.

## Structure
- `dds_sweep_pkg`: state enum (`SWEEP_IDLE`, `SWEEP_UP`, `SWEEP_DOWN`) and default widths `DDS_STEP_W`=32, `DDS_DWELL_W`=24.
- One sub-module, `sweep_dwell_timer`: loadable down-counter with `hold` and a `zero` flag, sized by `DWELL_WIDTH`.
- Next-value add/sub, limit compare and FSM stay in the top level.

## Test plan
- Single-shot sweep, `start_step`=100, `stop_step`=130, `delta`=10, `dwell`=3:
  - `step_out` = 100, 110, 120, 130, each for 4 cycles.
  - `done` pulses 16 cycles after the first `step_valid`; `sync_out` pulses once.
- Same settings with `repeat_en`=1: sequence repeats, `sync_out` every 16 cycles, no `done`.
- Carry boundary, `start_step`=0xFFFF_FFF0, `delta`=0x20, `stop_step`=0xFFFF_FFFF: one step only, then `done` with no wrap to 0x10.
- `stop` and `start` in the same cycle mid-sweep: IDLE next cycle, no `done`, `step_out` holds its value.
- `hold` high for 5 cycles during `dwell`=2: that step lasts 8 cycles; next value is correct.
- With macro, `bounce_en`=1, 0→20 in steps of 10, `dwell`=0: `step_out` = 0, 10, 20, 10, 0, then `done`.

Source files
------------

// File: rtl/dds_sweep_pkg.sv
// Shared widths and FSM state encodings for the DDS frequency-sweep sequencer.
package dds_sweep_pkg;

    localparam int DDS_STEP_W  = 32;
    localparam int DDS_DWELL_W = 24;

    typedef logic [1:0] sweep_state_t;

    localparam sweep_state_t SWEEP_IDLE = 2'd0;
    localparam sweep_state_t SWEEP_UP   = 2'd1;
    localparam sweep_state_t SWEEP_DOWN = 2'd2;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter. It stops at zero, freezes while hold_i is high,
// and flags zero_o when the current step has used up its dwell time.
module sweep_dwell_timer
    import dds_sweep_pkg::*;
#(
    parameter int DWELL_WIDTH = DDS_DWELL_W
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [DWELL_WIDTH-1:0] load_val_i,
    input  logic                   hold_i,
    output logic                   zero_o
);

    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;

    // A load takes priority over hold, so a new step always starts with a full dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next value comes from always_comb.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the DDS phase increment as a staircase.
// Define DDS_SWEEP_BOUNCE_EN to add the bounce_en_i port and the down-ramp state.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int STEP_WIDTH  = DDS_STEP_W,
    parameter int DWELL_WIDTH = DDS_DWELL_W
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   hold_i,
    input  logic                   repeat_en_i,
`ifdef DDS_SWEEP_BOUNCE_EN
    input  logic                   bounce_en_i,
`endif
    input  logic [STEP_WIDTH-1:0]  start_step_i,
    input  logic [STEP_WIDTH-1:0]  stop_step_i,
    input  logic [STEP_WIDTH-1:0]  delta_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    output logic [STEP_WIDTH-1:0]  step_out_o,
    output logic                   step_valid_o,
    output logic                   sync_out_o,
    output logic                   busy_o,
    output logic                   done_o
);

    sweep_state_t           state_q, state_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d;
    logic [STEP_WIDTH-1:0]  start_step_q, start_step_d;
    logic [STEP_WIDTH-1:0]  stop_step_q, stop_step_d;
    logic [STEP_WIDTH-1:0]  delta_q, delta_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   repeat_q, repeat_d;
    logic                   step_valid_q, step_valid_d;
    logic                   sync_q, sync_d;
    logic                   done_q, done_d;

    logic                   tmr_load;
    logic [DWELL_WIDTH-1:0] tmr_load_val;
    logic                   tmr_zero;
    logic                   advance;
    logic                   ramp_end;

    // The extra MSB catches wrap-around, so a ramp near the top never folds back to a small step.
    logic [STEP_WIDTH:0]    next_up;
    logic                   up_ok;

    assign next_up = {1'b0, step_q} + {1'b0, delta_q};
    assign up_ok   = !next_up[STEP_WIDTH] && (next_up[STEP_WIDTH-1:0] <= stop_step_q)
                     && (delta_q != '0);
    assign advance = tmr_zero && !hold_i;

`ifdef DDS_SWEEP_BOUNCE_EN
    logic                   bounce_q, bounce_d;
    logic [STEP_WIDTH:0]    next_dn;
    logic                   dn_ok;

    assign next_dn = {1'b0, step_q} - {1'b0, delta_q};
    assign dn_ok   = !next_dn[STEP_WIDTH] && (next_dn[STEP_WIDTH-1:0] >= start_step_q)
                     && (delta_q != '0);
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        start_step_d = start_step_q;
        stop_step_d  = stop_step_q;
        delta_d      = delta_q;
        dwell_d      = dwell_q;
        repeat_d     = repeat_q;
`ifdef DDS_SWEEP_BOUNCE_EN
        bounce_d     = bounce_q;
`endif
        step_valid_d = 1'b0;
        sync_d       = 1'b0;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = dwell_q;
        ramp_end     = 1'b0;

        if (stop_i) begin
            state_d = SWEEP_IDLE;
        end else if (start_i) begin
            start_step_d = start_step_i;
            stop_step_d  = stop_step_i;
            delta_d      = delta_i;
            dwell_d      = dwell_i;
            repeat_d     = repeat_en_i;
`ifdef DDS_SWEEP_BOUNCE_EN
            bounce_d     = bounce_en_i;
`endif
            step_d       = start_step_i;
            tmr_load     = 1'b1;
            tmr_load_val = dwell_i;
            step_valid_d = 1'b1;
            sync_d       = 1'b1;
            state_d      = SWEEP_UP;
        end else begin
            case (state_q)
                SWEEP_UP: begin
                    if (advance) begin
                        if (up_ok) begin
                            step_d       = next_up[STEP_WIDTH-1:0];
                            tmr_load     = 1'b1;
                            step_valid_d = 1'b1;
`ifdef DDS_SWEEP_BOUNCE_EN
                        end else if (bounce_q && dn_ok) begin
                            step_d       = next_dn[STEP_WIDTH-1:0];
                            tmr_load     = 1'b1;
                            step_valid_d = 1'b1;
                            state_d      = SWEEP_DOWN;
`endif
                        end else begin
                            ramp_end = 1'b1;
                        end
                    end
                end
`ifdef DDS_SWEEP_BOUNCE_EN
                SWEEP_DOWN: begin
                    if (advance) begin
                        if (dn_ok) begin
                            step_d       = next_dn[STEP_WIDTH-1:0];
                            tmr_load     = 1'b1;
                            step_valid_d = 1'b1;
                        end else begin
                            ramp_end = 1'b1;
                        end
                    end
                end
`else
                SWEEP_DOWN: state_d = SWEEP_IDLE;
`endif
                default: ;
            endcase

            if (ramp_end) begin
                if (repeat_q) begin
                    step_d       = start_step_q;
                    tmr_load     = 1'b1;
                    step_valid_d = 1'b1;
                    sync_d       = 1'b1;
                    state_d      = SWEEP_UP;
                end else begin
                    done_d  = 1'b1;
                    state_d = SWEEP_IDLE;
                end
            end
        end
    end

    // NOTE: the shadow settings are plain registers, so they are cleared with everything else on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= SWEEP_IDLE;
            step_q       <= '0;
            start_step_q <= '0;
            stop_step_q  <= '0;
            delta_q      <= '0;
            dwell_q      <= '0;
            repeat_q     <= 1'b0;
`ifdef DDS_SWEEP_BOUNCE_EN
            bounce_q     <= 1'b0;
`endif
            step_valid_q <= 1'b0;
            sync_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            start_step_q <= start_step_d;
            stop_step_q  <= stop_step_d;
            delta_q      <= delta_d;
            dwell_q      <= dwell_d;
            repeat_q     <= repeat_d;
`ifdef DDS_SWEEP_BOUNCE_EN
            bounce_q     <= bounce_d;
`endif
            step_valid_q <= step_valid_d;
            sync_q       <= sync_d;
            done_q       <= done_d;
        end
    end

    sweep_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .hold_i     (hold_i),
        .zero_o     (tmr_zero)
    );

    assign step_out_o   = step_q;
    assign step_valid_o = step_valid_q;
    assign sync_out_o   = sync_q;
    assign done_o       = done_q;
    assign busy_o       = (state_q != SWEEP_IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with hand-computed staircase expectations.
// The bounce scenario is compiled in only when DDS_SWEEP_BOUNCE_EN is defined.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        repeat_en_i = 1'b0;
    logic [31:0] start_step_i = '0;
    logic [31:0] stop_step_i = '0;
    logic [31:0] delta_i = '0;
    logic [23:0] dwell_i = '0;
    logic [31:0] step_out;
    logic        step_valid;
    logic        sync_out;
    logic        busy;
    logic        done;
`ifdef DDS_SWEEP_BOUNCE_EN
    logic        bounce_en_i = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .hold_i       (hold_i),
        .repeat_en_i  (repeat_en_i),
`ifdef DDS_SWEEP_BOUNCE_EN
        .bounce_en_i  (bounce_en_i),
`endif
        .start_step_i (start_step_i),
        .stop_step_i  (stop_step_i),
        .delta_i      (delta_i),
        .dwell_i      (dwell_i),
        .step_out_o   (step_out),
        .step_valid_o (step_valid),
        .sync_out_o   (sync_out),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are read 1 time unit after the rising edge, inputs are driven there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] d,
                           input logic [23:0] w, input logic r);
        start_step_i = s;
        stop_step_i  = e;
        delta_i      = d;
        dwell_i      = w;
        repeat_en_i  = r;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_stop();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset_i = 1'b0;
        check("reset step", step_out, 32'd0);
        check("reset busy", busy, 1'b0);
        check("reset valid", step_valid, 1'b0);
        check("reset sync", sync_out, 1'b0);
        check("reset done", done, 1'b0);

        // Single shot 100..130 by 10, dwell 3: four values of four cycles each.
        set_cfg(32'd100, 32'd130, 32'd10, 24'd3, 1'b0);
        pulse_start();
        check("t1 first step", step_out, 32'd100);
        check("t1 first valid", step_valid, 1'b1);
        check("t1 first sync", sync_out, 1'b1);
        check("t1 first busy", busy, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("t1 step k%0d", k), step_out, (k < 16) ? 32'(100 + 10 * (k / 4)) : 32'd130);
            check($sformatf("t1 valid k%0d", k), step_valid, ((k % 4 == 0) && (k < 16)) ? 1'b1 : 1'b0);
            check($sformatf("t1 done k%0d", k), done, (k == 16) ? 1'b1 : 1'b0);
            check($sformatf("t1 sync k%0d", k), sync_out, 1'b0);
            check($sformatf("t1 busy k%0d", k), busy, (k < 16) ? 1'b1 : 1'b0);
        end

        // Same ramp with repeat: restart every 16 cycles, never done.
        set_cfg(32'd100, 32'd130, 32'd10, 24'd3, 1'b1);
        pulse_start();
        check("t2 first sync", sync_out, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("t2 step k%0d", k), step_out, 32'(100 + 10 * ((k % 16) / 4)));
            check($sformatf("t2 sync k%0d", k), sync_out, (k % 16 == 0) ? 1'b1 : 1'b0);
            check($sformatf("t2 valid k%0d", k), step_valid, (k % 4 == 0) ? 1'b1 : 1'b0);
            check($sformatf("t2 done k%0d", k), done, 1'b0);
        end
        do_stop();
        check("t2 stop busy", busy, 1'b0);
        check("t2 stop step", step_out, 32'd120);
        check("t2 stop done", done, 1'b0);

        // Stop and start together mid-sweep: stop wins, nothing recaptured.
        set_cfg(32'd100, 32'd130, 32'd10, 24'd3, 1'b0);
        pulse_start();
        for (int k = 1; k <= 5; k++) tick();
        check("t3 pre step", step_out, 32'd110);
        start_step_i = 32'd500;
        stop_i  = 1'b1;
        start_i = 1'b1;
        tick();
        stop_i  = 1'b0;
        start_i = 1'b0;
        check("t3 busy", busy, 1'b0);
        check("t3 step", step_out, 32'd110);
        check("t3 done", done, 1'b0);
        check("t3 sync", sync_out, 1'b0);
        check("t3 valid", step_valid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t3 hold step %0d", k), step_out, 32'd110);
            check($sformatf("t3 idle done %0d", k), done, 1'b0);
        end

        // Hold for 5 cycles with dwell 2: step lasts 8 cycles; mid-sweep input changes ignored.
        set_cfg(32'd100, 32'd130, 32'd10, 24'd2, 1'b0);
        pulse_start();
        tick();
        hold_i      = 1'b1;
        delta_i     = 32'd1;
        stop_step_i = 32'd0;
        for (int k = 2; k <= 6; k++) begin
            tick();
            check($sformatf("t4 held step k%0d", k), step_out, 32'd100);
            check($sformatf("t4 held valid k%0d", k), step_valid, 1'b0);
        end
        hold_i = 1'b0;
        tick();
        check("t4 k7 step", step_out, 32'd100);
        tick();
        check("t4 k8 step", step_out, 32'd110);
        check("t4 k8 valid", step_valid, 1'b1);
        do_stop();

        // start_step above stop_step: one dwell of start_step, then done.
        set_cfg(32'd200, 32'd100, 32'd10, 24'd1, 1'b0);
        pulse_start();
        check("t5 step0", step_out, 32'd200);
        tick();
        check("t5 k1 done", done, 1'b0);
        tick();
        check("t5 k2 done", done, 1'b1);
        check("t5 k2 step", step_out, 32'd200);
        check("t5 k2 busy", busy, 1'b0);

        // delta = 0: ends at the first advance.
        set_cfg(32'd50, 32'd100, 32'd0, 24'd0, 1'b0);
        pulse_start();
        check("t6 step0", step_out, 32'd50);
        tick();
        check("t6 done", done, 1'b1);
        check("t6 step", step_out, 32'd50);
        check("t6 busy", busy, 1'b0);

        // Carry boundary: no wrap to 0x10.
        set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 24'd3, 1'b0);
        pulse_start();
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t7 step k%0d", k), step_out, 32'hFFFF_FFF0);
            check($sformatf("t7 done k%0d", k), done, (k == 4) ? 1'b1 : 1'b0);
            check($sformatf("t7 valid k%0d", k), step_valid, 1'b0);
        end
        check("t7 busy", busy, 1'b0);

        // Restart while busy, then reset mid-sweep.
        set_cfg(32'd100, 32'd130, 32'd10, 24'd3, 1'b0);
        pulse_start();
        tick();
        tick();
        start_step_i = 32'd7;
        pulse_start();
        check("t8 restart step", step_out, 32'd7);
        check("t8 restart sync", sync_out, 1'b1);
        check("t8 restart valid", step_valid, 1'b1);
        tick();
        check("t8 after sync", sync_out, 1'b0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("t8 reset step", step_out, 32'd0);
        check("t8 reset busy", busy, 1'b0);

`ifdef DDS_SWEEP_BOUNCE_EN
        // Bounce 0..20 by 10, dwell 0: 0, 10, 20, 10, 0, then done.
        begin
            logic [31:0] exp_seq [5];
            exp_seq[0] = 32'd0;
            exp_seq[1] = 32'd10;
            exp_seq[2] = 32'd20;
            exp_seq[3] = 32'd10;
            exp_seq[4] = 32'd0;
            set_cfg(32'd0, 32'd20, 32'd10, 24'd0, 1'b0);
            bounce_en_i = 1'b1;
            pulse_start();
            check("t9 step k0", step_out, exp_seq[0]);
            for (int k = 1; k <= 4; k++) begin
                tick();
                check($sformatf("t9 step k%0d", k), step_out, exp_seq[k]);
                check($sformatf("t9 valid k%0d", k), step_valid, 1'b1);
                check($sformatf("t9 done k%0d", k), done, 1'b0);
            end
            tick();
            check("t9 done", done, 1'b1);
            check("t9 final step", step_out, 32'd0);
            check("t9 busy", busy, 1'b0);
            bounce_en_i = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
